// File: rtl/mod_addsub_pipe.sv
// rtl/mod_addsub_pipe.sv - two-stage pipelined per-lane modular add/subtract with valid/ready handshakes
module mod_addsub_pipe #(
  parameter int WIDTH = 23,
  parameter int LANES = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic                   mode_i,
  input  logic [WIDTH-1:0]       q_i,
  input  logic [LANES*WIDTH-1:0] a_i,
  input  logic [LANES*WIDTH-1:0] b_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [LANES*WIDTH-1:0] c_o
);

  localparam int SW = WIDTH + 1;

  logic                   r_v1;
  logic                   r_v2;
  logic                   r_mode1;
  logic [WIDTH-1:0]       r_q1;
  logic [LANES*SW-1:0]    r_s1;
  logic [LANES*WIDTH-1:0] r_c2;

  logic                   w_ld1;
  logic                   w_ld2;
  logic [LANES*SW-1:0]    w_s1;
  logic [LANES*WIDTH-1:0] w_c2;
  logic [SW-1:0]          w_lane;

  assign w_ld2      = r_v1 & (~r_v2 | out_ready_i);
  assign in_ready_o = ~r_v1 | w_ld2;
  assign w_ld1      = in_valid_i & in_ready_o;

  // Bit WIDTH of each stage-1 lane is the carry (add) or borrow (sub).
  always_comb begin
    w_s1 = '0;
    for (int k = 0; k < LANES; k++) begin
      if (mode_i)
        w_s1[k*SW +: SW] = {1'b0, a_i[k*WIDTH +: WIDTH]} - {1'b0, b_i[k*WIDTH +: WIDTH]};
      else
        w_s1[k*SW +: SW] = {1'b0, a_i[k*WIDTH +: WIDTH]} + {1'b0, b_i[k*WIDTH +: WIDTH]};
    end
  end

  // A legal corrected result is below q, so the low WIDTH bits of the correction suffice.
  always_comb begin
    w_c2   = '0;
    w_lane = '0;
    for (int k = 0; k < LANES; k++) begin
      w_lane = r_s1[k*SW +: SW];
      if (r_mode1) begin
        if (w_lane[WIDTH])
          w_c2[k*WIDTH +: WIDTH] = w_lane[WIDTH-1:0] + r_q1;
        else
          w_c2[k*WIDTH +: WIDTH] = w_lane[WIDTH-1:0];
      end else begin
        if (w_lane >= {1'b0, r_q1})
          w_c2[k*WIDTH +: WIDTH] = w_lane[WIDTH-1:0] - r_q1;
        else
          w_c2[k*WIDTH +: WIDTH] = w_lane[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_mode1 <= 1'b0;
      r_q1    <= '0;
      r_s1    <= '0;
      r_c2    <= '0;
    end else begin
      if (w_ld1) begin
        r_v1    <= 1'b1;
        r_s1    <= w_s1;
        r_mode1 <= mode_i;
        r_q1    <= q_i;
      end else if (w_ld2) begin
        r_v1    <= 1'b0;
      end
      if (w_ld2) begin
        r_v2 <= 1'b1;
        r_c2 <= w_c2;
      end else if (out_ready_i) begin
        r_v2 <= 1'b0;
      end
    end
  end

  assign out_valid_o = r_v2;
  assign c_o         = r_c2;

endmodule
